// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/store control sequencer with memory-handshake stalls and debug counters.
// Define CPU_SEQ_HALT_EN to build the HALT state; otherwise is_halt is ignored and halted is tied low.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  op_class,
    input  logic        is_halt,
    input  logic        mem_ack,
    output logic [1:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        reg_read,
    output logic        alu_en,
    output logic        reg_write,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        halted,
    output logic [15:0] retired,
    output logic [7:0]  stall_cnt
);

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

`ifdef CPU_SEQ_HALT_EN
    // HALT shares the low bits of STORE so the reported phase is 11.
    typedef enum logic [2:0] {
        FETCH   = 3'b000,
        DECODE  = 3'b001,
        EXECUTE = 3'b010,
        STORE   = 3'b011,
        HALT    = 3'b111
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        STORE   = 2'b11
    } state_t;
`endif

    state_t state_q;
    state_t state_d;
    logic   is_mem_op;

    assign is_mem_op = (op_class == OP_LOAD) || (op_class == OP_STORE);
    assign state     = state_q[1:0];

`ifdef CPU_SEQ_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
    logic unused_is_halt;
    assign unused_is_halt = is_halt;
`endif

    // NOTE: every output and the next state get a default before the case, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        reg_read     = 1'b0;
        alu_en       = 1'b0;
        reg_write    = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                reg_read = 1'b1;
                state_d  = EXECUTE;
`ifdef CPU_SEQ_HALT_EN
                if (is_halt) begin
                    state_d = HALT;
                end
`endif
            end

            EXECUTE: begin
                alu_en = 1'b1;
                if (is_mem_op) begin
                    // Request and qualifiers are held until the ack cycle.
                    mem_req      = 1'b1;
                    mem_we       = (op_class == OP_STORE);
                    mem_addr_sel = 1'b1;
                    if (mem_ack) begin
                        state_d = STORE;
                    end
                end else begin
                    state_d = STORE;
                end
            end

            STORE: begin
                case (op_class)
                    OP_ALU, OP_LOAD: begin
                        reg_write = 1'b1;
                        pc_inc    = 1'b1;
                    end
                    OP_STORE: pc_inc  = 1'b1;
                    OP_JUMP:  pc_load = 1'b1;
                    default:  ;
                endcase
                state_d = FETCH;
            end

`ifdef CPU_SEQ_HALT_EN
            HALT: state_d = HALT;
`endif

            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            retired   <= 16'h0000;
            stall_cnt <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == STORE) begin
                retired <= retired + 16'h0001;
            end
            // Saturating count of cycles spent waiting on memory.
            if (mem_req && !mem_ack && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a per-instruction cycle model queues expected outputs,
// and a negedge monitor compares them against the DUT.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  op_class;
    logic        is_halt;
    logic        mem_ack;
    logic [1:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_load;
    logic        reg_read;
    logic        alu_en;
    logic        reg_write;
    logic        pc_inc;
    logic        pc_load;
    logic        halted;
    logic [15:0] retired;
    logic [7:0]  stall_cnt;

`ifdef CPU_SEQ_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [1:0] C_ALU = 2'b00, C_LOAD = 2'b01, C_STORE = 2'b10, C_JUMP = 2'b11;

    typedef struct packed {
        logic [1:0]  st;
        logic        req;
        logic        we;
        logic        sel;
        logic        irl;
        logic        rr;
        logic        alu;
        logic        rw;
        logic        pci;
        logic        pcl;
        logic        hlt;
        logic [15:0] ret;
        logic [7:0]  stl;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors;
    int          miscompares;
    int unsigned m_retired;
    int unsigned m_stall;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .op_class     (op_class),
        .is_halt      (is_halt),
        .mem_ack      (mem_ack),
        .state        (state),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .reg_read     (reg_read),
        .alu_en       (alu_en),
        .reg_write    (reg_write),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .halted       (halted),
        .retired      (retired),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [1:0] st, input logic req, input logic we,
                                input logic sel, input logic irl, input logic rr,
                                input logic alu, input logic rw, input logic pci,
                                input logic pcl, input logic hlt);
        exp_t e;
        e = '0;
        e.st = st;  e.req = req; e.we  = we;  e.sel = sel; e.irl = irl;
        e.rr = rr;  e.alu = alu; e.rw  = rw;  e.pci = pci; e.pcl = pcl;
        e.hlt = hlt;
        return e;
    endfunction

    // One clock of stimulus: queue the expectation, then advance the counter model.
    task automatic step(input logic ack, input exp_t e_in);
        exp_t e;
        e = e_in;
        e.ret = m_retired[15:0];
        e.stl = m_stall[7:0];
        mem_ack = ack;
        exp_q.push_back(e);
        if (e.req && !ack && m_stall < 255) m_stall++;
        if (e.st == 2'b11 && !e.hlt) m_retired = (m_retired + 1) % 65536;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_ack  = 1'b1;
        op_class = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ack   = 1'b0;
        m_retired = 0;
        m_stall   = 0;
    endtask

    // Expected cycle sequence of one instruction. abort_at >= 0 stops after that many
    // EXECUTE wait cycles so the caller can reset in the middle of a memory wait.
    task automatic run_instr(input logic [1:0] cls, input int fw, input int ew,
                             input bit halt, input int abort_at);
        logic mem_op;
        logic we;
        mem_op = (cls == C_LOAD) || (cls == C_STORE);
        we     = (cls == C_STORE);
        for (int i = 0; i < fw; i++) begin
            op_class = 2'($urandom_range(0, 3));
            is_halt  = 1'($urandom_range(0, 1));
            step(1'b0, mk(2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        op_class = cls;
        is_halt  = halt;
        step(1'b1, mk(2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step(1'($urandom_range(0, 1)), mk(2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        if (HALT_EN && halt) begin
            for (int i = 0; i < 20; i++)
                step(1'($urandom_range(0, 1)), mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        if (mem_op) begin
            for (int i = 0; i < ew; i++) begin
                if (abort_at == i) return;
                step(1'b0, mk(2'b10, 1, we, 1, 0, 0, 1, 0, 0, 0, 0));
            end
            step(1'b1, mk(2'b10, 1, we, 1, 0, 0, 1, 0, 0, 0, 0));
        end else begin
            step(1'($urandom_range(0, 1)), mk(2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        step(1'($urandom_range(0, 1)),
             mk(2'b11, 0, 0, 0, 0, 0, 0,
                (cls == C_ALU) || (cls == C_LOAD), cls != C_JUMP, cls == C_JUMP, 0));
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {state, mem_req, mem_we, mem_addr_sel, ir_load, reg_read, alu_en,
                       reg_write, pc_inc, pc_load, halted, retired, stall_cnt};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d @%0t: dut st=%b req/we/sel=%b%b%b irl/rr/alu=%b%b%b rw/pci/pcl/hlt=%b%b%b%b ret=%h stl=%0d, required st=%b req/we/sel=%b%b%b irl/rr/alu=%b%b%b rw/pci/pcl/hlt=%b%b%b%b ret=%h stl=%0d",
                             vectors, $time, act.st, act.req, act.we, act.sel, act.irl, act.rr,
                             act.alu, act.rw, act.pci, act.pcl, act.hlt, act.ret, act.stl,
                             e.st, e.req, e.we, e.sel, e.irl, e.rr, e.alu, e.rw, e.pci,
                             e.pcl, e.hlt, e.ret, e.stl);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_retired   = 0;
        m_stall     = 0;
        reset       = 1'b1;
        op_class    = C_ALU;
        is_halt     = 1'b0;
        mem_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Directed cases.
        run_instr(C_ALU,   0, 0, 1'b0, -1);
        run_instr(C_ALU,   3, 0, 1'b0, -1);
        run_instr(C_STORE, 0, 2, 1'b0, -1);
        run_instr(C_JUMP,  0, 0, 1'b0, -1);
        run_instr(C_LOAD,  0, 0, 1'b0, -1);
        run_instr(C_LOAD,  1, 5, 1'b0, 3);
        do_reset();
        run_instr(C_ALU,   0, 0, 1'b1, -1);
        if (HALT_EN) do_reset();
        run_instr(C_ALU,   0, 0, 1'b0, -1);
        // Long waits drive stall_cnt into saturation.
        run_instr(C_LOAD, 200, 100, 1'b0, -1);
        run_instr(C_STORE, 2, 1, 1'b0, -1);
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 250; n++) begin
            logic [1:0] cls;
            int         fw;
            int         ew;
            bit         halt;
            int         abort_at;
            cls      = 2'($urandom_range(0, 3));
            fw       = $urandom_range(0, 3);
            ew       = $urandom_range(0, 3);
            halt     = ($urandom_range(0, 15) == 0);
            abort_at = -1;
            if ((cls == C_LOAD || cls == C_STORE) && ew > 0 && $urandom_range(0, 9) == 0)
                abort_at = $urandom_range(0, ew - 1);
            run_instr(cls, fw, ew, halt, abort_at);
            if ((HALT_EN && halt) || abort_at >= 0) do_reset();
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
